mandel_cfg_loader: RTL
======================

# mandel_cfg_loader

Parametrised configuration loader for the Mandelbrot pipeline. It assembles a render configuration (corner, maxiter, res) from `NUM_WORDS` strobed words on a narrow `DATA_W` bus. A new configuration commits only when the renderer is idle, and `new_input` pulses once per committed configuration. It sits between the bus slave and the render controller and adds word capture, timeout, abort and overrun detection.

## Interface
- `DATA_W`, 16: width of one configuration word.
- `NUM_WORDS`, 4: words per configuration. `NUM_WORDS*DATA_W` must be ≥ 55 (elaboration-time check).
- `TIMEOUT`, 1000: maximum idle cycles allowed between words of one transaction.
- `clk`, in, 1: clock.
- `n_rst`, in, 1: reset, asynchronous, active-low.
- `wr_data`, in, `DATA_W`: word data, sampled on a write rising edge.
- `write`, in, 1: write level. Each low→high transition is one word.
- `abort`, in, 1: synchronous request to drop the partial transaction.
- `frame_busy`, in, 1: renderer active. The commit waits while this is high.
- `corner`, out, 36: active corner.
- `maxiter`, out, 10: active maxiter.
- `res`, out, 9: active resolution.
- `new_input`, out, 1: one-cycle pulse; the active outputs have just changed.
- `pending`, out, 1: a transaction is in progress (state is not IDLE).
- `word_cnt`, out, `$clog2(NUM_WORDS+1)`: number of words captured so far.
- `err_timeout`, out, 1: one-cycle pulse; the partial transaction was discarded after a timeout.
- `err_overrun`, out, 1: one-cycle pulse; a write edge was ignored because it arrived after the transaction was complete.

## Operation
- **Edge detect:** `write_q` is registered. `wr_edge = write & ~write_q`.
- **Word packing:** word k is stored in `shadow[k*DATA_W +: DATA_W]`, word 0 first.
- **Field mapping:** corner = `shadow[35:0]`, maxiter = `shadow[45:36]`, res = `shadow[54:46]`. Unused upper bits are ignored.
- **IDLE:**
  - `wr_edge` captures word 0, sets `word_cnt`=1 and moves to COLLECT.
  - If `NUM_WORDS`=1, the next state follows the commit rule below instead.
- **COLLECT:**
  - `wr_edge` captures word `word_cnt`, increments `word_cnt` and clears the idle counter.
  - On capture of the last word, go to LOAD if `frame_busy`=0, else WAIT_FRAME.
  - With no edge, the idle counter increments. When it reaches `TIMEOUT`: clear `shadow` and `word_cnt`, pulse `err_timeout`, go to IDLE.
- **WAIT_FRAME:** stay while `frame_busy`=1, then go to LOAD.
- **LOAD:** the active registers take their shadow fields at the end of this cycle. Go to READY.
- **READY:** `new_input`=1 for this cycle only. Clear `word_cnt` and go to IDLE.
- **Abort:** `abort`=1 in COLLECT or WAIT_FRAME clears `word_cnt` and the idle counter and returns to IDLE; the active outputs are unchanged. Abort is ignored in IDLE, LOAD and READY.
- **Priority:** abort beats timeout, and timeout beats `wr_edge` in the same cycle.
- **Overrun:** `wr_edge` in WAIT_FRAME, LOAD or READY is discarded and pulses `err_overrun`; `shadow` is not modified.
- **Shadow retention:** `shadow` is not cleared on commit. Only words actually captured overwrite it.

## Timing
- **Reset values:**
  - All outputs are 0; state is IDLE; `shadow`=0.
  - The idle counter is 0.
  - `write_q` resets to 1, so a `write` held high through reset release is not counted until it falls and rises again.
- **Latency:** last-word edge sampled at clock t, with `frame_busy`=0 →
  - LOAD during cycle t+1;
  - outputs change at the edge ending t+1;
  - `new_input` is high during t+2.
- **Deferred commit:** if `frame_busy` falls while in WAIT_FRAME, LOAD follows on the next cycle.
- **Back-to-back:** a `wr_edge` in the IDLE cycle right after READY starts a new transaction with no gap.
- **Minimum word spacing:** 2 cycles (high, low).
- **Idle counter width:** `$clog2(TIMEOUT+1)`. It counts only in COLLECT and saturates at `TIMEOUT`.
- **Mid-operation reset:** asynchronously returns to the reset state. The active outputs go to 0 and any partial transaction is lost.

## Structure
- **Package `mandel_pkg`:**
  - `CFG_STATE` enum: IDLE, COLLECT, WAIT_FRAME, LOAD, READY.
  - Field constants: `CORNER_W`=36, `MAXITER_W`=10, `RES_W`=9, `CORNER_LSB`=0, `MAXITER_LSB`=36, `RES_LSB`=46, `CFG_W`=55.
- **Sub-module `rise_detect`:**
  - Registers `write_q` with reset value 1 and outputs `wr_edge`.
  - Reused by other strobe inputs.
- **Top level:** FSM, shadow register, counters and active registers.

## Test plan
- **Nominal load:** defaults; words 0x1111, 0x2222, 0x3333, 0x0444; `frame_busy`=0 → corner=0x322221111, maxiter=0x333, res=0x110, one `new_input` pulse 2 cycles after the 4th edge.
- **Deferred commit:** as the nominal load, with `frame_busy`=1 for 50 cycles after the 4th word → `pending`=1 throughout and outputs unchanged. `new_input` comes 2 cycles after `frame_busy` falls. A 5th edge during the wait pulses `err_overrun` and the values stay the same.
- **Timeout:** 2 words, then 1000 idle cycles → `err_timeout` pulse, `word_cnt`=0, outputs unchanged. A following 4-word load succeeds.
- **Abort:** 3 words, then `abort` asserted in the same cycle as the 4th edge → IDLE, no `new_input`, outputs unchanged.
- **Reset:** hold `write`=1 across `n_rst` release → no capture until a fall and rise. Assert `n_rst` mid-transaction → all outputs 0 immediately.
- **Parameter sweep:** `DATA_W`=8, `NUM_WORDS`=7 → 7-word load, with 55 bits mapped exactly as the field constants specify.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared types and field layout for the Mandelbrot configuration path.
package mandel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WAIT_FRAME,
    LOAD,
    READY
  } CFG_STATE;

  localparam int CORNER_W    = 36;
  localparam int MAXITER_W   = 10;
  localparam int RES_W       = 9;
  localparam int CORNER_LSB  = 0;
  localparam int MAXITER_LSB = 36;
  localparam int RES_LSB     = 46;
  localparam int CFG_W       = 55;

endpackage

// File: rtl/mandel_cfg_loader_rise_detect.sv
// Rising-edge detector for level strobes. The history register resets high so a
// level already asserted when reset releases is not mistaken for a new strobe.
module rise_detect (
  input  logic clk,
  input  logic n_rst,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/mandel_cfg_loader.sv
// Assembles a render configuration from strobed bus words and commits it to the
// active registers only while the renderer is idle.
module mandel_cfg_loader
  import mandel_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_WORDS = 4,
  parameter int TIMEOUT   = 1000
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             write,
  input  logic                             abort,
  input  logic                             frame_busy,
  output logic [CORNER_W-1:0]              corner,
  output logic [MAXITER_W-1:0]             maxiter,
  output logic [RES_W-1:0]                 res,
  output logic                             new_input,
  output logic                             pending,
  output logic [$clog2(NUM_WORDS+1)-1:0]   word_cnt,
  output logic                             err_timeout,
  output logic                             err_overrun
);

  localparam int CNT_W  = $clog2(NUM_WORDS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int SH_W   = NUM_WORDS * DATA_W;

  generate
    if (SH_W < CFG_W) begin : g_width_check
      $error("mandel_cfg_loader: NUM_WORDS*DATA_W must cover the 55-bit configuration");
    end
  endgenerate

  CFG_STATE          state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [CFG_W-1:0]  shadow;
  logic              wr_edge;
  logic              last_word;

  logic capture, cnt_clr, idle_inc, shadow_clr, load_act;
  logic timeout_ev, overrun_ev;

  rise_detect u_write_edge (
    .clk   (clk),
    .n_rst (n_rst),
    .level (write),
    .rise  (wr_edge)
  );

  assign last_word = (word_cnt == CNT_W'(NUM_WORDS - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    cnt_clr    = 1'b0;
    idle_inc   = 1'b0;
    shadow_clr = 1'b0;
    load_act   = 1'b0;
    timeout_ev = 1'b0;
    overrun_ev = 1'b0;
    case (state)
      IDLE: begin
        if (wr_edge) begin
          capture = 1'b1;
          if (last_word) begin
            state_nxt = frame_busy ? WAIT_FRAME : LOAD;
          end else begin
            state_nxt = COLLECT;
          end
        end
      end
      // Priority inside a transaction: abort, then timeout, then a new word.
      COLLECT: begin
        if (abort) begin
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
        end else if (idle_cnt == IDLE_W'(TIMEOUT)) begin
          timeout_ev = 1'b1;
          cnt_clr    = 1'b1;
          shadow_clr = 1'b1;
          state_nxt  = IDLE;
        end else if (wr_edge) begin
          capture = 1'b1;
          if (last_word) begin
            state_nxt = frame_busy ? WAIT_FRAME : LOAD;
          end
        end else begin
          idle_inc = 1'b1;
        end
      end
      WAIT_FRAME: begin
        overrun_ev = wr_edge;
        if (abort) begin
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
        end else if (!frame_busy) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        overrun_ev = wr_edge;
        load_act   = 1'b1;
        state_nxt  = READY;
      end
      READY: begin
        overrun_ev = wr_edge;
        cnt_clr    = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Idle counter runs only while collecting without traffic; anything else clears it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idle_cnt <= '0;
    end else if (idle_inc) begin
      if (idle_cnt != IDLE_W'(TIMEOUT)) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end else begin
      idle_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_cnt <= '0;
    end else if (cnt_clr) begin
      word_cnt <= '0;
    end else if (capture) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  // Only the bits that land inside the configuration are stored; word k owns
  // shadow bits [k*DATA_W +: DATA_W].
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shadow <= '0;
    end else if (shadow_clr) begin
      shadow <= '0;
    end else if (capture) begin
      for (int b = 0; b < CFG_W; b++) begin
        if (word_cnt == CNT_W'(b / DATA_W)) begin
          shadow[b] <= wr_data[b % DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      corner  <= '0;
      maxiter <= '0;
      res     <= '0;
    end else if (load_act) begin
      corner  <= shadow[CORNER_LSB +: CORNER_W];
      maxiter <= shadow[MAXITER_LSB +: MAXITER_W];
      res     <= shadow[RES_LSB +: RES_W];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_timeout <= timeout_ev;
      err_overrun <= overrun_ev;
    end
  end

  assign new_input = (state == READY);
  assign pending   = (state != IDLE);

endmodule
